// File: rtl/iob_uart_responder_if.sv
// Native-bus link between the tester-side master and the UART responder.
// Ports (signals):
//   valid   - request, held by the master until ready
//   address - register select
//   wdata   - write data
//   wstrb   - 1 = write, 0 = read
//   rdata   - registered read data
//   ready   - one-cycle acknowledge
interface iob_uart_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) ();
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              wstrb;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/iob_uart_responder.sv
// Native-bus UART peripheral: programmable baud divider, one-byte 8N1
// transmitter and one-byte 8N1 receiver.
// Ports:
//   clk - system clock
//   rst - synchronous reset, active low
//   bus - slave side of the valid/ready register bus
//   txd - serial out, idle high
//   rxd - serial in, asynchronous to clk
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for a TXDATA write
//   TX_START | driving the start bit (0)
//   TX_DATA  | shifting out 8 data bits, LSB first
//   TX_STOP  | driving the stop bit (1)
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | half-bit wait, then confirm the start bit is still low
//   RX_DATA  | sampling 8 data bits, LSB first
//   RX_STOP  | sampling the stop bit, delivering the byte if it is 1
module iob_uart_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DIV_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    iob_uart_responder_if.slave  bus,
    output logic                 txd,
    input  logic                 rxd
);

    localparam logic [ADDR_W-1:0] A_SOFT_RST = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_DIV      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TXDATA   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RXDATA   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_TXEN     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_RXEN     = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_TXREADY  = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_RXREADY  = ADDR_W'(7);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // bus / register file
    logic              ready_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rd_mux;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  div_wr;
    logic              txen;
    logic              rxen;
    logic              access;
    logic              wr;
    logic              rd;
    logic              soft_rst;
    logic              tx_load;
    logic              rx_read;
    logic              wdata_unused;

    // reload values for the bit timers; div-1 gives div cycles per bit
    logic [DIV_W-1:0]  div_m1;
    logic [DIV_W-1:0]  div_half_m1;

    // transmitter
    tx_state_t         tx_state, tx_state_d;
    logic [DIV_W-1:0]  tx_timer, tx_timer_d;
    logic [7:0]        tx_shift, tx_shift_d;
    logic [2:0]        tx_bit, tx_bit_d;
    logic              txd_d;
    logic              tx_ready, tx_ready_d;

    // receiver
    rx_state_t         rx_state, rx_state_d;
    logic [DIV_W-1:0]  rx_timer, rx_timer_d;
    logic [7:0]        rx_shift, rx_shift_d;
    logic [2:0]        rx_bit, rx_bit_d;
    logic              rx_done;
    logic              rx_meta, rx_sync, rx_prev;
    logic [7:0]        rx_data;
    logic              rx_ready;

    assign bus.ready    = ready_q;
    assign bus.rdata    = rdata_q;
    assign access       = bus.valid & ~ready_q;
    assign wr           = access & bus.wstrb;
    assign rd           = access & ~bus.wstrb;
    assign soft_rst     = wr && (bus.address == A_SOFT_RST) && bus.wdata[0];
    assign tx_load      = wr && (bus.address == A_TXDATA) && txen && tx_ready;
    assign rx_read      = rd && (bus.address == A_RXDATA);
    assign wdata_unused = ^bus.wdata[DATA_W-1:DIV_W];

    // a divider below 2 would leave no room for the half-bit RX wait
    assign div_wr = (bus.wdata[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2)
                                                        : bus.wdata[DIV_W-1:0];
    assign div_m1      = div - DIV_W'(1);
    assign div_half_m1 = (div >> 1) - DIV_W'(1);

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_RXDATA:  rd_mux = DATA_W'(rx_data);
            A_TXREADY: rd_mux = DATA_W'(tx_ready);
            A_RXREADY: rd_mux = DATA_W'(rx_ready);
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            div     <= '0;
            txen    <= 1'b0;
            rxen    <= 1'b0;
        end else begin
            ready_q <= bus.valid & ~ready_q;
            if (access) begin
                rdata_q <= wr ? '0 : rd_mux;
                if (wr) begin
                    case (bus.address)
                        A_SOFT_RST: if (bus.wdata[0]) begin
                            txen <= 1'b0;
                            rxen <= 1'b0;
                        end
                        A_DIV:  div  <= div_wr;
                        A_TXEN: txen <= bus.wdata[0];
                        A_RXEN: rxen <= bus.wdata[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- transmitter ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_timer <= tx_timer_d;
            tx_shift <= tx_shift_d;
            tx_bit   <= tx_bit_d;
            txd      <= txd_d;
            tx_ready <= tx_ready_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_timer_d = tx_timer;
        tx_shift_d = tx_shift;
        tx_bit_d   = tx_bit;
        txd_d      = txd;
        tx_ready_d = tx_ready;
        case (tx_state)
            TX_IDLE: begin
                if (tx_load) begin
                    tx_state_d = TX_START;
                    tx_shift_d = bus.wdata[7:0];
                    tx_timer_d = div_m1;
                    txd_d      = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            TX_START: begin
                if (tx_timer == '0) begin
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shift[0];
                    tx_shift_d = {1'b0, tx_shift[7:1]};
                    tx_bit_d   = '0;
                    tx_timer_d = div_m1;
                end else begin
                    tx_timer_d = tx_timer - DIV_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_timer == '0) begin
                    tx_timer_d = div_m1;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        txd_d      = tx_shift[0];
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                        tx_bit_d   = tx_bit + 3'd1;
                    end
                end else begin
                    tx_timer_d = tx_timer - DIV_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_timer == '0) begin
                    tx_state_d = TX_IDLE;
                    tx_ready_d = 1'b1;
                end else begin
                    tx_timer_d = tx_timer - DIV_W'(1);
                end
            end
        endcase
        if (soft_rst) begin
            tx_state_d = TX_IDLE;
            txd_d      = 1'b1;
            tx_ready_d = 1'b1;
        end
    end

    // ---------------- receiver ----------------
    // rx_prev is one cycle behind rx_sync so a start is only seen on a
    // genuine 1->0 edge; a line left low after a bad frame never restarts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_timer <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
            rx_data  <= '0;
            rx_ready <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            rx_timer <= rx_timer_d;
            rx_shift <= rx_shift_d;
            rx_bit   <= rx_bit_d;
            if (rx_done) begin
                rx_data <= rx_shift;
            end
            // a byte landing in the same cycle as an RXDATA read keeps the flag set
            if (soft_rst) begin
                rx_ready <= 1'b0;
            end else if (rx_done) begin
                rx_ready <= 1'b1;
            end else if (rx_read) begin
                rx_ready <= 1'b0;
            end
        end
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_timer_d = rx_timer;
        rx_shift_d = rx_shift;
        rx_bit_d   = rx_bit;
        rx_done    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rxen && rx_prev && !rx_sync) begin
                    rx_state_d = RX_START;
                    rx_timer_d = div_half_m1;
                end
            end
            RX_START: begin
                if (rx_timer == '0) begin
                    if (rx_sync) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                        rx_timer_d = div_m1;
                    end
                end else begin
                    rx_timer_d = rx_timer - DIV_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_timer == '0) begin
                    rx_shift_d = {rx_sync, rx_shift[7:1]};
                    rx_timer_d = div_m1;
                    if (rx_bit == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit + 3'd1;
                    end
                end else begin
                    rx_timer_d = rx_timer - DIV_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_timer == '0) begin
                    rx_state_d = RX_IDLE;
                    rx_done    = rx_sync;
                end else begin
                    rx_timer_d = rx_timer - DIV_W'(1);
                end
            end
        endcase
        if (soft_rst) begin
            rx_state_d = RX_IDLE;
            rx_done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_iob_uart_responder.sv
// Directed bench for iob_uart_responder: register access, TX framing,
// RX framing and error handling, soft reset and divider clamp.
`timescale 1ns/1ps
module tb_iob_uart_responder;

    logic clk;
    logic rst;
    logic txd;
    logic rxd;

    int total;
    int bad;

    iob_uart_responder_if #(.DATA_W(32), .ADDR_W(3)) bus_if ();

    iob_uart_responder #(.DATA_W(32), .ADDR_W(3), .DIV_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .txd (txd),
        .rxd (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are observed on the falling edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_access(input logic [2:0] a, input logic [31:0] d,
                              input logic we, output logic [31:0] q);
        int n;
        @(negedge clk);
        bus_if.valid   = 1'b1;
        bus_if.address = a;
        bus_if.wdata   = d;
        bus_if.wstrb   = we;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.ready !== 1'b1 && n < 8);
        q = bus_if.rdata;
        total++;
        if (bus_if.ready !== 1'b1) begin
            bad++;
            $display("FAIL bus_ready addr=%0d ready=%b required=1", a, bus_if.ready);
        end
        bus_if.valid = 1'b0;
        bus_if.wstrb = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus_access(a, d, 1'b1, q);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] q);
        bus_access(a, 32'h0, 1'b0, q);
    endtask

    // 10 bits of 8 cycles each, leaving rxd at the stop-bit level
    task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = f[k];
            wait_cycles(8);
        end
    endtask

    task automatic test_reset;
        logic [31:0] q;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rxd = ~rxd;
            @(negedge clk);
        end
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b required=1", txd); end
        total++;
        if (bus_if.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b required=0", bus_if.ready); end
        total++;
        if (bus_if.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h required=0", bus_if.rdata); end
        rxd = 1'b1;
        rst = 1'b1;
        wait_cycles(3);
        bus_read(3'd6, q);
        total++;
        if (q !== 32'h1) begin bad++; $display("FAIL reset_txready got=%h required=1", q); end
        bus_read(3'd7, q);
        total++;
        if (q !== 32'h0) begin bad++; $display("FAIL reset_rxready got=%h required=0", q); end
    endtask

    // valid held high: ready pulses every other cycle, each access registered
    task automatic test_back_to_back;
        @(negedge clk);
        bus_if.valid   = 1'b1;
        bus_if.wstrb   = 1'b0;
        bus_if.address = 3'd6;
        @(negedge clk);
        total++;
        if (bus_if.ready !== 1'b1 || bus_if.rdata !== 32'h1) begin
            bad++;
            $display("FAIL b2b_first ready=%b rdata=%h required ready=1 rdata=1", bus_if.ready, bus_if.rdata);
        end
        bus_if.address = 3'd7;
        @(negedge clk);
        total++;
        if (bus_if.ready !== 1'b0) begin bad++; $display("FAIL b2b_gap ready=%b required=0", bus_if.ready); end
        @(negedge clk);
        total++;
        if (bus_if.ready !== 1'b1 || bus_if.rdata !== 32'h0) begin
            bad++;
            $display("FAIL b2b_second ready=%b rdata=%h required ready=1 rdata=0", bus_if.ready, bus_if.rdata);
        end
        bus_if.valid = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_tx;
        logic [9:0]  f;
        logic        e;
        logic [31:0] q;
        int          glitches;
        f = {1'b1, 8'hA5, 1'b0};
        bus_write(3'd1, 32'd4);
        bus_write(3'd4, 32'd1);
        bus_write(3'd2, 32'hA5);
        for (int i = 0; i < 44; i++) begin
            if (i > 0) @(negedge clk);
            e = (i < 40) ? f[i / 4] : 1'b1;
            total++;
            if (txd !== e) begin
                bad++;
                $display("FAIL tx_a5 cycle=%0d txd=%b required=%b", i, txd, e);
            end
        end
        // second frame: probe TXREADY and try an overlapping TXDATA write
        bus_write(3'd2, 32'h5A);
        bus_read(3'd6, q);
        total++;
        if (q !== 32'h0) begin bad++; $display("FAIL tx_ready_mid got=%h required=0", q); end
        bus_write(3'd2, 32'hFF);
        wait_cycles(34);
        bus_read(3'd6, q);
        total++;
        if (q !== 32'h0) begin bad++; $display("FAIL tx_ready_stop got=%h required=0", q); end
        bus_read(3'd6, q);
        total++;
        if (q !== 32'h1) begin bad++; $display("FAIL tx_ready_after got=%h required=1", q); end
        glitches = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) glitches++;
        end
        total++;
        if (glitches != 0) begin bad++; $display("FAIL tx_dropped low_cycles=%0d required=0", glitches); end
    endtask

    task automatic test_rx;
        logic [31:0] q;
        bus_write(3'd1, 32'd8);
        bus_write(3'd5, 32'd1);
        drive_rx_frame(8'h3C, 1'b1);
        bus_read(3'd7, q);
        total++;
        if (q !== 32'h1) begin bad++; $display("FAIL rx_ready_set got=%h required=1", q); end
        bus_read(3'd3, q);
        total++;
        if (q !== 32'h0000003C) begin bad++; $display("FAIL rx_data got=%h required=0000003c", q); end
        bus_read(3'd7, q);
        total++;
        if (q !== 32'h0) begin bad++; $display("FAIL rx_ready_clr got=%h required=0", q); end
    endtask

    task automatic test_rx_errors;
        logic [31:0] q;
        rxd = 1'b0;
        wait_cycles(2);
        rxd = 1'b1;
        wait_cycles(100);
        bus_read(3'd7, q);
        total++;
        if (q !== 32'h0) begin bad++; $display("FAIL rx_false_start got=%h required=0", q); end
        drive_rx_frame(8'h55, 1'b0);
        wait_cycles(40);
        rxd = 1'b1;
        wait_cycles(20);
        bus_read(3'd7, q);
        total++;
        if (q !== 32'h0) begin bad++; $display("FAIL rx_framing got=%h required=0", q); end
        drive_rx_frame(8'h96, 1'b1);
        bus_read(3'd3, q);
        total++;
        if (q !== 32'h00000096) begin bad++; $display("FAIL rx_recover got=%h required=00000096", q); end
    endtask

    task automatic test_overrun;
        logic [31:0] q;
        drive_rx_frame(8'h11, 1'b1);
        drive_rx_frame(8'h22, 1'b1);
        bus_read(3'd7, q);
        total++;
        if (q !== 32'h1) begin bad++; $display("FAIL ovr_ready got=%h required=1", q); end
        bus_read(3'd3, q);
        total++;
        if (q !== 32'h00000022) begin bad++; $display("FAIL ovr_data got=%h required=00000022", q); end
        bus_read(3'd7, q);
        total++;
        if (q !== 32'h0) begin bad++; $display("FAIL ovr_clr got=%h required=0", q); end
    endtask

    task automatic test_soft_reset;
        logic [31:0] q;
        int          glitches;
        bus_write(3'd1, 32'd4);
        bus_write(3'd4, 32'd1);
        bus_write(3'd2, 32'h00);
        wait_cycles(13);
        total++;
        if (txd !== 1'b0) begin bad++; $display("FAIL srst_pre txd=%b required=0", txd); end
        bus_write(3'd0, 32'd1);
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL srst_txd txd=%b required=1", txd); end
        bus_read(3'd6, q);
        total++;
        if (q !== 32'h1) begin bad++; $display("FAIL srst_txready got=%h required=1", q); end
        // txen was cleared, so this load must be dropped
        bus_write(3'd2, 32'h00);
        glitches = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) glitches++;
        end
        total++;
        if (glitches != 0) begin bad++; $display("FAIL srst_txen low_cycles=%0d required=0", glitches); end
        // divider survives: start + 8 zero bits = 36 low cycles
        bus_write(3'd4, 32'd1);
        bus_write(3'd2, 32'h00);
        wait_cycles(35);
        total++;
        if (txd !== 1'b0) begin bad++; $display("FAIL srst_div_low txd=%b required=0", txd); end
        wait_cycles(1);
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL srst_div_stop txd=%b required=1", txd); end
        wait_cycles(10);
    endtask

    task automatic test_div_clamp;
        bus_write(3'd1, 32'd1);
        bus_write(3'd2, 32'h00);
        total++;
        if (txd !== 1'b0) begin bad++; $display("FAIL clamp_start txd=%b required=0", txd); end
        wait_cycles(17);
        total++;
        if (txd !== 1'b0) begin bad++; $display("FAIL clamp_last_data txd=%b required=0", txd); end
        wait_cycles(1);
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL clamp_stop txd=%b required=1", txd); end
        wait_cycles(4);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b0;
        rxd            = 1'b1;
        bus_if.valid   = 1'b0;
        bus_if.address = '0;
        bus_if.wdata   = '0;
        bus_if.wstrb   = 1'b0;
        test_reset();
        test_back_to_back();
        test_tx();
        test_rx();
        test_rx_errors();
        test_overrun();
        test_soft_reset();
        test_div_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
